// File: rtl/phase_sequencer.sv
// phase_sequencer: button-driven programming sequencer.
// Decodes the {in1,in2} command pair on press edges, stages `data`, commits
// it to one slot per phase and advances the phase counter.
// Optional build macro: DEBOUNCE_EN (adds a DB_CYCLES stability filter on cmd).
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PHASE_W    = 2,
    parameter int DATA_W     = 4,
    parameter int BLINK_DIV  = 8,
    parameter int DB_CYCLES  = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in1,
    input  logic                           in2,
    input  logic [DATA_W-1:0]              data,
    output logic [PHASE_W-1:0]             phase,
    output logic                           phase_plus,
    output logic [DATA_W-1:0]              diode,
    output logic [NUM_PHASES*DATA_W-1:0]   prog_word,
    output logic                           done,
    output logic                           err
);

    localparam logic [1:0] CMD_GIVE    = 2'b11;
    localparam logic [1:0] CMD_CONFIRM = 2'b01;
    localparam logic [1:0] CMD_END     = 2'b00;
    localparam logic [1:0] CMD_IDLE    = 2'b10;

    localparam int                 BLINK_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_HELD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          cmd_raw;
    logic [1:0]          cmd_q;
    logic [1:0]          cmd_prev;
    logic                press;
    logic [DATA_W-1:0]   staging;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_on;

    assign cmd_raw = {in1, in2};

`ifdef DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [1:0]      cmd_cand;
    logic [DB_W-1:0] db_cnt;

    // Command register follows the raw pair only after DB_CYCLES identical samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_cand <= CMD_IDLE;
            db_cnt   <= '0;
            cmd_q    <= CMD_IDLE;
        end else begin
            cmd_cand <= cmd_raw;
            if (cmd_raw != cmd_cand) begin
                db_cnt <= DB_W'(1);
            end else begin
                if (db_cnt < DB_W'(DB_CYCLES))
                    db_cnt <= db_cnt + DB_W'(1);
                if (db_cnt >= DB_W'(DB_CYCLES - 1))
                    cmd_q <= cmd_raw;
            end
        end
    end
`else
    // Command register is a plain one-cycle sample of the raw pair
    always_ff @(posedge clk) begin
        if (!rst_n)
            cmd_q <= CMD_IDLE;
        else
            cmd_q <= cmd_raw;
    end
`endif

    // Previous command value, used to find the release-to-press edge
    always_ff @(posedge clk) begin
        if (!rst_n)
            cmd_prev <= CMD_IDLE;
        else
            cmd_prev <= cmd_q;
    end

    // A command counts only when leaving IDLE; holds and code-to-code moves are ignored
    assign press = (cmd_prev == CMD_IDLE) && (cmd_q != CMD_IDLE);

    // Sequencer FSM with registered outputs and slot storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            phase      <= '0;
            phase_plus <= 1'b0;
            diode      <= '0;
            prog_word  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            staging    <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b0;
        end else begin
            phase_plus <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_WAIT: begin
                    diode <= '0;
                    if (press && cmd_q == CMD_GIVE) begin
                        staging   <= data;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        diode     <= data;
                        state     <= S_HELD;
                    end else if (press && cmd_q == CMD_END) begin
                        err <= 1'b1;
                    end
                end
                S_HELD: begin
                    if (press && cmd_q == CMD_GIVE) begin
                        staging   <= data;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        diode     <= data;
                    end else if (press && cmd_q == CMD_CONFIRM) begin
                        prog_word[phase*DATA_W +: DATA_W] <= staging;
                        diode <= staging;
                        state <= S_COMMIT;
                    end else begin
                        if (press && cmd_q == CMD_END)
                            err <= 1'b1;
                        // Blink: staging for BLINK_DIV cycles, then blank for BLINK_DIV
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink_on  <= ~blink_on;
                            diode     <= blink_on ? '0 : staging;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                            diode     <= blink_on ? staging : '0;
                        end
                    end
                end
                S_COMMIT: begin
                    diode <= staging;
                    if (press && cmd_q == CMD_GIVE) begin
                        staging   <= data;
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
                        diode     <= data;
                        state     <= S_HELD;
                    end else if (press && cmd_q == CMD_END) begin
                        phase_plus <= 1'b1;
                        if (phase == LAST_PHASE) begin
                            done  <= 1'b1;
                            diode <= '1;
                            state <= S_DONE;
                        end else begin
                            phase <= phase + PHASE_W'(1);
                            diode <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    diode <= '1;
                end
                default: begin
                    diode <= '0;
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule
